pipe_skid_stage: RTL and testbench
==================================

Name: pipe_skid_stage

Overview:
Parametrised elastic inter-stage pipeline register, the successor to the fixed keep/clr stage registers between CPU stages.
- Replaces the global stall ("keep") with a per-stage valid/ready handshake.
- A 2-entry skid buffer gives full throughput while breaking the ready path combinationally.
- Carries an opaque payload plus the interrupt-request sideband bit.
- Supports synchronous flush to a NOP bubble.

Parameters:
DATA_W, 32, payload width in bits (instruction, PC+4, ALU out, load data and dest reg concatenated by the instantiator).
NOP_VAL, 0, payload value presented on out_data when the stage is empty or flushed.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
clr  in  1  flush; discards all held entries on the next edge.
in_valid  in  1  upstream entry present.
in_ready  out  1  stage can accept an entry this cycle.
in_data  in  DATA_W  upstream payload.
in_intreq  in  1  interrupt-request sideband travelling with in_data.
out_valid  out  1  downstream entry present.
out_ready  in  1  downstream accepts this cycle.
out_data  out  DATA_W  head payload; NOP_VAL when out_valid=0.
out_intreq  out  1  head sideband bit; 0 when out_valid=0.
occupancy  out  2  entries held (0..2).

Behaviour:
- Storage: main register (head) and skid register, each holding payload plus intreq plus a valid bit.
- States: EMPTY (0 entries), ONE (main valid), FULL (main and skid valid). occupancy equals the state encoding 0/1/2.
- in_ready is registered: in_ready = (state != FULL). It has no combinational path from out_ready.
- Accept event: acc = in_valid & in_ready. Drain event: drn = out_valid & out_ready.
- Transitions, when rst=0 and clr=0:
  - EMPTY: acc -> ONE, main<=in.
  - ONE:
    - acc & !drn -> FULL, skid<=in.
    - acc & drn -> ONE, main<=in.
    - !acc & drn -> EMPTY.
    - Otherwise hold.
  - FULL: drn -> ONE, main<=skid. Otherwise hold. No accept is possible since in_ready=0.
- Ordering: strictly FIFO. The skid entry is never presented before main.
- Latency: 1 cycle from accept to out_valid when EMPTY. Throughput is 1 entry/cycle with out_ready held high.
- Flush: clr=1 forces EMPTY on the next edge.
  - Same-cycle in_valid is dropped, even if in_ready=1.
  - Same-cycle drn still counts downstream as a completed transfer; the stage just holds nothing after the edge.
  - Flush clears the held intreq bits (a flushed instruction raises no interrupt).
- Reset: rst=1 is highest priority over clr and handshakes. After the edge:
  - state=EMPTY, out_valid=0, out_data=NOP_VAL, out_intreq=0, in_ready=1, occupancy=0.
  - Reset mid-operation discards everything.
- Output data path: out_data and out_intreq are taken directly from the main register. The block guarantees main payload = NOP_VAL and main intreq = 0 whenever main is invalid, so no output mux is needed.
- Payload stability: while out_valid=1 and out_ready=0, out_data/out_intreq are held stable.

Optional Feature:
Macro PIPE_STALL_CNT_EN.
- Defined: adds output port stall_cnt [15:0].
  - Increments on every cycle with out_valid=1 and out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by rst only; clr does not clear it.
- Undefined: port and counter absent. Handshake behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - State typedef (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2).
  - Stall-counter width constant (16).
  - Default NOP payload constant.
- Sub-module pipe_entry_reg: one payload+intreq+valid register with load/clear enables, instantiated twice (main, skid).

Test Plan:
1. Reset: rst=1 for 2 cycles with in_valid=1, in_data=32'hDEAD -> out_valid=0, out_data=0, in_ready=1, occupancy=0 after release.
2. Streaming: out_ready=1, feed 1,2,3,4 back-to-back -> out_data 1,2,3,4 on consecutive cycles, each 1 cycle after accept; occupancy stays 1.
3. Backpressure: out_ready=0, send A=5, B=6 -> occupancy=2, in_ready=0, C=7 held off. Then out_ready=1 -> outputs 5,6,7 in order with no loss or duplication.
4. Flush: in FULL with in_valid=1, pulse clr -> next cycle occupancy=0, out_valid=0, out_data=0. The entry offered during clr never appears.
5. Intreq: send data 9 with in_intreq=1 then flush before drain -> out_intreq never 1. Repeat without flush -> out_intreq=1 exactly while out_data=9 is valid.
6. With PIPE_STALL_CNT_EN: hold out_ready=0 for 70000 cycles with an entry held -> stall_cnt=16'hFFFF. Assert rst -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage.
// Optional stall counter is enabled by PIPE_STALL_CNT_EN.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam int STALL_CNT_W = 16;

  localparam logic [31:0] NOP_PAYLOAD = 32'h0;

endpackage

// File: rtl/pipe_entry_reg.sv
// One payload+intreq+valid register with load and clear.
// Cleared entries always read NOP_VAL with intreq low.
module pipe_entry_reg #(
  parameter int              DATA_W  = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              ld,
  input  logic [DATA_W-1:0] d_data,
  input  logic              d_intreq,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  output logic              q_intreq
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q_valid  <= 1'b0;
      q_data   <= NOP_VAL;
      q_intreq <= 1'b0;
    end else if (ld) begin
      q_valid  <= 1'b1;
      q_data   <= d_data;
      q_intreq <= d_intreq;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic 2-entry skid pipeline register with flush.
// PIPE_STALL_CNT_EN adds a saturating stall_cnt output.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(NOP_PAYLOAD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_intreq,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_intreq,
`ifdef PIPE_STALL_CNT_EN
  output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
  output logic [1:0]        occupancy
);

  state_t state, state_n;

  logic acc, drn;
  logic main_ld, main_skid, main_clr;
  logic skid_ld, skid_clr;
  logic skid_valid, skid_intreq;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] main_d;
  logic main_d_ir;

  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;
  assign occupancy = state;
  assign main_d    = main_skid ? skid_data : in_data;
  assign main_d_ir = main_skid ? skid_intreq : in_intreq;

  always_comb begin
    state_n   = state;
    main_ld   = 1'b0;
    main_skid = 1'b0;
    main_clr  = 1'b0;
    skid_ld   = 1'b0;
    skid_clr  = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (acc) begin
          state_n = ST_ONE;
          main_ld = 1'b1;
        end
      end
      ST_ONE: begin
        unique case (1'b1)
          acc & ~drn: begin
            state_n = ST_FULL;
            skid_ld = 1'b1;
          end
          acc & drn: main_ld = 1'b1;
          ~acc & drn: begin
            state_n  = ST_EMPTY;
            main_clr = 1'b1;
          end
          default: ;
        endcase
      end
      ST_FULL: begin
        if (drn) begin
          state_n   = ST_ONE;
          main_ld   = 1'b1;
          main_skid = 1'b1;
          skid_clr  = 1'b1;
        end
      end
      default: state_n = ST_EMPTY;
    endcase
    // Flush wins over any handshake in the same cycle.
    if (clr) begin
      state_n  = ST_EMPTY;
      main_ld  = 1'b0;
      skid_ld  = 1'b0;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_n;
      in_ready <= (state_n != ST_FULL);
    end
  end

  pipe_entry_reg #(
    .DATA_W (DATA_W),
    .NOP_VAL(NOP_VAL)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .clr     (main_clr),
    .ld      (main_ld),
    .d_data  (main_d),
    .d_intreq(main_d_ir),
    .q_valid (out_valid),
    .q_data  (out_data),
    .q_intreq(out_intreq)
  );

  pipe_entry_reg #(
    .DATA_W (DATA_W),
    .NOP_VAL(NOP_VAL)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clr     (skid_clr),
    .ld      (skid_ld),
    .d_data  (in_data),
    .d_intreq(in_intreq),
    .q_valid (skid_valid),
    .q_data  (skid_data),
    .q_intreq(skid_intreq)
  );

`ifdef PIPE_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage.
// Define PIPE_STALL_CNT_EN to also exercise stall_cnt.
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        in_intreq;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        out_intreq;
  logic [1:0]  occupancy;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int drained = 0;
  logic [32:0] q[$];

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(32), .NOP_VAL(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_intreq (in_intreq),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_intreq(out_intreq),
`ifdef PIPE_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .occupancy (occupancy)
  );

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference FIFO: accepted entries in order, dropped on flush/reset.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      check("occ", 64'(occupancy), 64'(q.size()));
      check("in_ready", 64'(in_ready), 64'(q.size() < 2));
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (!out_valid) begin
        check("nop_data", 64'(out_data), 64'h0);
        check("nop_intreq", 64'(out_intreq), 64'h0);
      end else if (q.size() != 0) begin
        check("head", 64'({out_intreq, out_data}), 64'(q[0]));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("extra_out", 64'(out_data), 64'hx);
        else void'(q.pop_front());
        drained++;
      end
      if (clr) q.delete();
      else if (in_valid && in_ready) q.push_back({in_intreq, in_data});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic ir);
    logic ok;
    ok = 1'b0;
    in_valid  = 1'b1;
    in_data   = d;
    in_intreq = ir;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 64'(d), 64'h0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEAD; in_intreq = 1'b0;
    out_ready = 1'b0;
    tick(2);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_occ", 64'(occupancy), 64'h0);
    tick(1);

    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) send(32'(k), 1'b0);
    tick(3);

    out_ready = 1'b0;
    send(32'd5, 1'b0);
    send(32'd6, 1'b0);
    in_valid = 1'b1; in_data = 32'd7;
    repeat (3) begin
      @(negedge clk);
      check("bp_occ", 64'(occupancy), 64'h2);
      check("bp_in_ready", 64'(in_ready), 64'h0);
      check("bp_head", 64'(out_data), 64'h5);
    end
    tick(1);
    out_ready = 1'b1;
    send(32'd7, 1'b0);
    tick(4);

    out_ready = 1'b0;
    send(32'd10, 1'b0);
    send(32'd11, 1'b0);
    in_valid = 1'b1; in_data = 32'd12; clr = 1'b1;
    tick(1);
    clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("fl_occ", 64'(occupancy), 64'h0);
    check("fl_out_valid", 64'(out_valid), 64'h0);
    check("fl_out_data", 64'(out_data), 64'h0);
    tick(1);
    out_ready = 1'b1;
    tick(3);

    out_ready = 1'b0;
    send(32'd9, 1'b1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("fl_intreq", 64'(out_intreq), 64'h0);
    end
    tick(1);
    send(32'd9, 1'b1);
    tick(3);

    check("drained", 64'(drained), 64'd8);
    check("q_empty", 64'(q.size()), 64'd0);

`ifdef PIPE_STALL_CNT_EN
    out_ready = 1'b0;
    send(32'd3, 1'b0);
    tick(70000);
    check("stall_sat", 64'(stall_cnt), 64'hFFFF);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("stall_rst", 64'(stall_cnt), 64'h0);
    tick(1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
